// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-through bypass and a per-register busy
// scoreboard that lets the decode stage detect read-after-write hazards.
module regfile_mp_sb #(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0]        rd_data_o,
    output logic [NRD-1:0]             rd_busy_o,
    input  logic [NWR-1:0]             wr_en_i,
    input  logic [NWR*$clog2(NREGS)-1:0] wr_addr_i,
    input  logic [NWR*XLEN-1:0]        wr_data_i,
    input  logic                       issue_en_i,
    input  logic [$clog2(NREGS)-1:0]   issue_addr_i,
    input  logic                       flush_i
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  regs_r     [NREGS];
    logic [XLEN-1:0]  regs_nxt_s [NREGS];
    logic [NREGS-1:0] busy_r;
    logic [NREGS-1:0] busy_nxt_s;

    // Next storage and scoreboard state; later write ports overwrite earlier ones,
    // and issue is applied last so it beats both flush and a completing write.
    always_comb begin
        logic [AW-1:0] wa_s;
        logic          wr_ok_s;
        logic          iss_ok_s;
        regs_nxt_s = regs_r;
        busy_nxt_s = busy_r;
        wa_s       = '0;
        wr_ok_s    = 1'b0;
        for (int j = 0; j < NWR; j++) begin
            wa_s    = wr_addr_i[j*AW +: AW];
            wr_ok_s = wr_en_i[j] && !((ZERO_R0 != 0) && (wa_s == '0));
            regs_nxt_s[wa_s] = wr_ok_s ? wr_data_i[j*XLEN +: XLEN] : regs_nxt_s[wa_s];
            busy_nxt_s[wa_s] = wr_en_i[j] ? 1'b0 : busy_nxt_s[wa_s];
        end
        busy_nxt_s = flush_i ? '0 : busy_nxt_s;
        iss_ok_s   = issue_en_i && !((ZERO_R0 != 0) && (issue_addr_i == '0));
        busy_nxt_s[issue_addr_i] = iss_ok_s ? 1'b1 : busy_nxt_s[issue_addr_i];
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
            busy_r <= '0;
        end else begin
            regs_r <= regs_nxt_s;
            busy_r <= busy_nxt_s;
        end
    end

    // Read ports: storage, overridden by the highest matching write port, then R0 and
    // reset gating. Issue and flush deliberately do not reach this path.
    always_comb begin
        logic [AW-1:0]   ra_s;
        logic [XLEN-1:0] d_s;
        logic            b_s;
        logic            hit_s;
        rd_data_o = '0;
        rd_busy_o = '0;
        ra_s      = '0;
        d_s       = '0;
        b_s       = 1'b0;
        hit_s     = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            ra_s = rd_addr_i[k*AW +: AW];
            d_s  = regs_r[ra_s];
            b_s  = busy_r[ra_s];
            for (int j = 0; j < NWR; j++) begin
                hit_s = wr_en_i[j] && (wr_addr_i[j*AW +: AW] == ra_s);
                d_s   = hit_s ? wr_data_i[j*XLEN +: XLEN] : d_s;
                b_s   = hit_s ? 1'b0 : b_s;
            end
            if (((ZERO_R0 != 0) && (ra_s == '0)) || !rst) begin
                d_s = '0;
                b_s = 1'b0;
            end else begin
                d_s = d_s;
                b_s = b_s;
            end
            rd_data_o[k*XLEN +: XLEN] = d_s;
            rd_busy_o[k]              = b_s;
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: directed scenarios plus random traffic, checked
// against a behavioural register-file model.
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int AW = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 issue_en;
    logic [AW-1:0]        issue_addr;
    logic                 flush;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_R0(1)) dut (
        .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr), .flush_i(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NRD*XLEN-1:0] data;
        logic [NRD-1:0]      busy;
        int                  tid;
    } exp_t;

    exp_t            q[$];
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    int              vectors = 0;
    int              errors = 0;
    int              tid = 0;

    // Monitor: compare each cycle's read ports against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            for (int k = 0; k < NRD; k++) begin
                vectors++;
                if (rd_data[k*XLEN +: XLEN] !== e.data[k*XLEN +: XLEN]) begin
                    errors++;
                    $display("FAIL data t%0d port%0d: got %h want %h", e.tid, k,
                             rd_data[k*XLEN +: XLEN], e.data[k*XLEN +: XLEN]);
                end
                vectors++;
                if (rd_busy[k] !== e.busy[k]) begin
                    errors++;
                    $display("FAIL busy t%0d port%0d: got %b want %b", e.tid, k,
                             rd_busy[k], e.busy[k]);
                end
            end
        end
    end

    function automatic exp_t model_read();
        exp_t e;
        e.tid  = tid;
        e.data = '0;
        e.busy = '0;
        for (int k = 0; k < NRD; k++) begin
            int a;
            logic [XLEN-1:0] d;
            bit b;
            a = int'(rd_addr[k*AW +: AW]);
            d = m_regs[a];
            b = m_busy[a];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                    d = wr_data[j*XLEN +: XLEN];
                    b = 1'b0;
                end
            end
            if (!rst || a == 0) begin
                d = '0;
                b = 1'b0;
            end
            e.data[k*XLEN +: XLEN] = d;
            e.busy[k] = b;
        end
        return e;
    endfunction

    task automatic model_clock();
        logic [XLEN-1:0] nr [NREGS];
        if (!rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
            return;
        end
        nr = m_regs;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != 0) nr[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
        end
        for (int r = 0; r < NREGS; r++) begin
            bit written = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == r) written = 1'b1;
            end
            if (issue_en && int'(issue_addr) == r && r != 0) m_busy[r] = 1'b1;
            else if (flush) m_busy[r] = 1'b0;
            else if (written) m_busy[r] = 1'b0;
        end
        m_regs = nr;
    endtask

    task automatic idle();
        rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; flush = 1'b0; rd_addr = '0;
    endtask

    task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
        wr_en[j] = 1'b1;
        wr_addr[j*AW +: AW] = AW'(a);
        wr_data[j*XLEN +: XLEN] = d;
    endtask

    task automatic set_rd(input int k, input int a);
        rd_addr[k*AW +: AW] = AW'(a);
    endtask

    // Queue the expectation for the current inputs, clock once, then return to idle.
    task automatic step();
        q.push_back(model_read());
        @(posedge clk);
        model_clock();
        #1;
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b0;
        @(posedge clk); #1;
        tid = 0; rst = 1'b0; set_rd(0, 31); step();
        rst = 1'b0; step();

        // T1: preload, reset, sweep all addresses.
        tid = 1;
        set_wr(0, 31, 32'hA5A5A5A5); set_wr(1, 1, 32'h12345678); issue_en = 1'b1; issue_addr = 5'd6; step();
        set_rd(0, 31); set_rd(1, 1); step();
        rst = 1'b0; step();
        for (int a = 0; a < NREGS; a += 2) begin
            set_rd(0, a); set_rd(1, a + 1); step();
        end

        // T2: bypass then storage.
        tid = 2;
        set_wr(0, 5, 32'hDEADBEEF); set_rd(1, 5); step();
        set_rd(1, 5); step();

        // T3: collision, port 1 wins.
        tid = 3;
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7); set_rd(1, 7); step();
        set_rd(0, 7); step();

        // T4: issue, then completing write.
        tid = 4;
        issue_en = 1'b1; issue_addr = 5'd9; set_rd(0, 9); step();
        set_rd(0, 9); step();
        set_wr(1, 9, 32'h33); set_rd(0, 9); step();
        set_rd(0, 9); step();

        // T5: issue with write, issue with flush.
        tid = 5;
        issue_en = 1'b1; issue_addr = 5'd3; set_wr(0, 3, 32'h55); step();
        set_rd(0, 3); issue_en = 1'b1; issue_addr = 5'd8; step();
        issue_en = 1'b1; issue_addr = 5'd4; flush = 1'b1; set_rd(0, 3); set_rd(1, 8); step();
        set_rd(0, 4); set_rd(1, 3); step();
        set_rd(0, 8); step();

        // T6: R0 stays zero; reset discards a same-cycle write.
        tid = 6;
        set_wr(0, 0, 32'hFF); issue_en = 1'b1; issue_addr = 5'd0; set_rd(0, 0); step();
        set_rd(0, 0); step();
        set_wr(0, 2, 32'h77); step();
        rst = 1'b0; set_wr(1, 2, 32'h44); set_rd(0, 2); step();
        set_rd(0, 2); step();

        // Random traffic.
        tid = 7;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 59) != 0);
            wr_en = NWR'($urandom());
            wr_addr = NWR*AW'($urandom());
            wr_data = {$urandom(), $urandom()};
            issue_en = ($urandom_range(0, 2) == 0);
            issue_addr = AW'($urandom());
            flush = ($urandom_range(0, 15) == 0);
            rd_addr = ($urandom_range(0, 1) == 0) ? wr_addr : NRD*AW'($urandom());
            step();
        end

        repeat (2) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
